// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   One stage of an instruction pipeline. It carries an instruction/PC pair
//   from an upstream valid/ready handshake to a downstream valid/ready
//   handshake. The stage also supports a flush (branch/jump redirect), a
//   hazard hold, and a saturating count of the cycles in which it presents
//   no entry.
//
// Build option:
//   PIPE_SKID_EN  undefined -> one entry; in_ready is combinational from the
//                              downstream ready.
//                 defined   -> two entries (main plus skid); in_ready comes
//                              from registered state (skid empty), so no
//                              combinational path runs from out_ready to
//                              in_ready.
//
// Parameters:
//   DATA_W    instruction width
//   PC_W      program-counter width
//   NOP_INSN  instruction presented while the stage is empty
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   flush       drop every held entry and any same-cycle input
//   hold        freeze all stage state (out_ready is ignored)
//   in_valid    upstream offers in_ir/in_pc
//   in_ready    stage accepts the offered entry this cycle
//   in_ir       incoming instruction
//   in_pc       incoming PC
//   out_valid   stage presents a valid entry
//   out_ready   downstream consumes the presented entry
//   out_ir      presented instruction (NOP_INSN when empty)
//   out_pc      presented PC (zero when empty)
//   bubble_cnt  saturating count of edges seen with out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_INSN = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_ir,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ir,
    output logic [PC_W-1:0]   out_pc,
    output logic [15:0]       bubble_cnt
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Main entry (the one presented downstream).
    logic              vld_p1;
    logic              vld_p1_n;
    logic [DATA_W-1:0] ir_p1;
    logic [PC_W-1:0]   pc_p1;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;

`ifdef PIPE_SKID_EN
    // Skid entry: catches an accepted entry while main is stuck.
    logic              vld_p0;
    logic              vld_p0_n;
    logic [DATA_W-1:0] ir_p0;
    logic [PC_W-1:0]   pc_p0;
    logic              load_main_skid;
    logic              load_skid;

    // vld_p0 is a flop, so in_ready depends only on registered state plus
    // the stall/redirect controls. rst gating keeps in_ready low while reset
    // is asserted.
    assign in_ready = rst && !vld_p0 && !hold && !flush;
`else
    assign in_ready = rst && (!vld_p1 || out_ready) && !hold && !flush;
`endif

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = vld_p1 && out_ready && !hold;

    always_comb begin
        vld_p1_n       = vld_p1;
        load_main_in   = 1'b0;
`ifdef PIPE_SKID_EN
        vld_p0_n       = vld_p0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
`endif
        if (flush) begin
            vld_p1_n = 1'b0;
`ifdef PIPE_SKID_EN
            vld_p0_n = 1'b0;
`endif
        end else if (!hold) begin
            if (out_xfer) begin
`ifdef PIPE_SKID_EN
                // An occupied skid implies in_ready=0, so no input competes.
                if (vld_p0) begin
                    load_main_skid = 1'b1;
                    vld_p0_n       = 1'b0;
                end else
`endif
                if (in_xfer) begin
                    load_main_in = 1'b1;
                end else begin
                    vld_p1_n = 1'b0;
                end
            end else if (in_xfer) begin
`ifdef PIPE_SKID_EN
                if (vld_p1) begin
                    load_skid = 1'b1;
                    vld_p0_n  = 1'b1;
                end else
`endif
                begin
                    load_main_in = 1'b1;
                    vld_p1_n     = 1'b1;
                end
            end
        end
    end

    // ---- stage register boundary: control state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
`ifdef PIPE_SKID_EN
            vld_p0     <= 1'b0;
`endif
            bubble_cnt <= 16'd0;
        end else begin
            vld_p1 <= vld_p1_n;
`ifdef PIPE_SKID_EN
            vld_p0 <= vld_p0_n;
`endif
            if (!vld_p1) begin
                bubble_cnt <= sat_inc16(bubble_cnt);
            end
        end
    end

    // ---- stage register boundary: payload (qualified by the valid flags) ----
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            ir_p1 <= in_ir;
            pc_p1 <= in_pc;
        end
`ifdef PIPE_SKID_EN
        else if (load_main_skid) begin
            ir_p1 <= ir_p0;
            pc_p1 <= pc_p0;
        end
        if (load_skid) begin
            ir_p0 <= in_ir;
            pc_p0 <= in_pc;
        end
`endif
    end

    assign out_valid = vld_p1;
    assign out_ir    = vld_p1 ? ir_p1 : NOP_INSN;
    assign out_pc    = vld_p1 ? pc_p1 : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic [15:0] bubble_cnt;

    int checks;
    int failures;

    pipe_stage_reg #(
        .DATA_W   (32),
        .PC_W     (32),
        .NOP_INSN (32'h00000013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .hold       (hold),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ir      (in_ir),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ir     (out_ir),
        .out_pc     (out_pc),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid actual=%b required=0", out_valid); end
        checks++; if (out_ir !== NOP) begin failures++; $display("FAIL rst_out_ir actual=%h required=%h", out_ir, NOP); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc actual=%h required=0", out_pc); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready actual=%b required=0", in_ready); end
        tick();
        tick();
        checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL rst_bubble actual=%0d required=0", bubble_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready actual=%b required=1", in_ready); end
        hold = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL post_rst_hold_in_ready actual=%b required=0", in_ready); end
        hold = 1'b0;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ir     = 32'h00A00093;
        in_pc     = 32'h100;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready actual=%b required=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid actual=%b required=1", out_valid); end
        checks++; if (out_ir !== 32'h00A00093) begin failures++; $display("FAIL single_ir actual=%h required=00a00093", out_ir); end
        checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL single_pc actual=%h required=100", out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid actual=%b required=0", out_valid); end
        checks++; if (out_ir !== NOP) begin failures++; $display("FAIL single_drain_ir actual=%h required=%h", out_ir, NOP); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL single_drain_pc actual=%h required=0", out_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [31:0] exp_ir;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_pc   = 32'(i * 4);
            exp_ir   = 32'h10000013 + 32'(i);
            in_valid = 1'b1;
            in_pc    = exp_pc;
            in_ir    = exp_ir;
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] actual=%b required=1", i, out_valid); end
            checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL stream_pc[%0d] actual=%h required=%h", i, out_pc, exp_pc); end
            checks++; if (out_ir !== exp_ir) begin failures++; $display("FAIL stream_ir[%0d] actual=%h required=%h", i, out_ir, exp_ir); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid actual=%b required=0", out_valid); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h40;
        in_ir     = 32'h00100093;
        tick();
        hold      = 1'b1;
        in_pc     = 32'h44;
        in_ir     = 32'h00200093;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d] actual=%b required=0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin failures++; $display("FAIL hold_out[%0d] actual=%b/%h required=1/40", i, out_valid, out_pc); end
        end
        hold = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_in_ready actual=%b required=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44 || out_ir !== 32'h00200093) begin failures++; $display("FAIL hold_resume actual=%b/%h/%h required=1/44/00200093", out_valid, out_pc, out_ir); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_drain actual=%b required=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h60;
        in_ir     = 32'h00300093;
        tick();
        flush = 1'b1;
        in_pc = 32'h80;
        in_ir = 32'h00400093;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready actual=%b required=0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid actual=%b required=0", out_valid); end
        checks++; if (out_ir !== NOP) begin failures++; $display("FAIL flush_ir actual=%h required=%h", out_ir, NOP); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL flush_pc actual=%h required=0", out_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL flush_leak[%0d] actual=%b/%h required=0/0", i, out_valid, out_pc); end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h600;
        in_ir     = 32'h00500093;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_ir !== 32'h00500093) begin failures++; $display("FAIL stall_stable[%0d] actual=%b/%h/%h required=1/600/00500093", i, out_valid, out_pc, out_ir); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain actual=%b required=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h200;
        in_ir     = 32'h00600093;
        tick();
        in_pc = 32'h204;
        in_ir = 32'h00700093;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready actual=%b required=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_ir !== 32'h00700093) begin failures++; $display("FAIL b2b_replace actual=%b/%h/%h required=1/204/00700093", out_valid, out_pc, out_ir); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain actual=%b required=0", out_valid); end
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        in_ir     = 32'h00800093;
        tick();
        checks++; if (out_pc !== 32'h300) begin failures++; $display("FAIL skid_first actual=%h required=300", out_pc); end
        out_ready = 1'b0;
        in_pc     = 32'h304;
        in_ir     = 32'h00900093;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_accept_ready actual=%b required=1", in_ready); end
        tick();
        in_pc = 32'h308;
        in_ir = 32'h00A00093;
        #1;
        checks++; if (out_pc !== 32'h300 || in_ready !== 1'b0) begin failures++; $display("FAIL skid_full actual=%h/%b required=300/0", out_pc, in_ready); end
        tick();
        checks++; if (out_pc !== 32'h300 || in_ready !== 1'b0) begin failures++; $display("FAIL skid_full2 actual=%h/%b required=300/0", out_pc, in_ready); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h304 || out_ir !== 32'h00900093 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_drain actual=%h/%h/%b required=304/00900093/1", out_pc, out_ir, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h308) begin failures++; $display("FAIL skid_last actual=%b/%h required=1/308", out_valid, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty actual=%b required=0", out_valid); end
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        in_ir     = 32'h00B00093;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_loaded actual=%b required=1", out_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_ir !== NOP || in_ready !== 1'b0) begin failures++; $display("FAIL rmid_async actual=%b/%h/%h/%b required=0/0/%h/0", out_valid, out_pc, out_ir, in_ready, NOP); end
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_after actual=%b required=0", out_valid); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL bubble_rst actual=%0d required=0", bubble_cnt); end
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            hold  = (k == 2 || k == 3);
            flush = (k == 4);
            tick();
        end
        hold  = 1'b0;
        flush = 1'b0;
        checks++; if (bubble_cnt !== 16'd5) begin failures++; $display("FAIL bubble_count actual=%0d required=5", bubble_cnt); end
        repeat (70000) tick();
        checks++; if (bubble_cnt !== 16'hFFFF) begin failures++; $display("FAIL bubble_sat actual=%h required=ffff", bubble_cnt); end
        repeat (5) tick();
        checks++; if (bubble_cnt !== 16'hFFFF) begin failures++; $display("FAIL bubble_hold_sat actual=%h required=ffff", bubble_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL bubble_clear actual=%0d required=0", bubble_cnt); end
        rst = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b0;
        in_ir     = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_hold();
        test_flush();
        test_stall();
        test_back_to_back();
`ifdef PIPE_SKID_EN
        test_skid();
`endif
        test_reset_mid();
        test_bubble();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the instruction payload.
REQ-002 Parameter PC_W, default 32: width of the program-counter payload.
REQ-003 Parameter NOP_INSN, default 32'h00000013: instruction value driven on out_ir while the stage is empty.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  discard all held entries (branch or jump redirect).
REQ-007 hold  input  1  hazard stall: freezes all stage state.
REQ-008 in_valid  input  1  upstream offers in_ir/in_pc this cycle.
REQ-009 in_ready  output  1  stage accepts the offered entry this cycle.
REQ-010 in_ir  input  DATA_W  incoming instruction.
REQ-011 in_pc  input  PC_W  incoming PC.
REQ-012 out_valid  output  1  stage presents a valid entry.
REQ-013 out_ready  input  1  downstream consumes the presented entry.
REQ-014 out_ir  output  DATA_W  presented instruction.
REQ-015 out_pc  output  PC_W  presented PC.
REQ-016 bubble_cnt  output  16  saturating count of cycles with out_valid=0.

Function
REQ-017 An input transfer occurs on a rising edge where in_valid=1 and in_ready=1; an output transfer occurs where out_valid=1, out_ready=1 and hold=0.
REQ-018 Latency is 1 cycle: an entry accepted at edge N is presented from edge N onward (out_valid=1 in cycle N+1) when the stage was empty.
REQ-019 Entries leave in acceptance order; there is no loss or duplication except on flush.
REQ-020 When out_valid=0: out_ir=NOP_INSN and out_pc=0.
REQ-021 Flush has priority over hold and all transfers: next edge empties the stage (out_valid=0, out_ir=NOP_INSN, out_pc=0) and drops any same-cycle input.
REQ-022 in_ready=0 whenever flush=1 or hold=1.
REQ-023 With hold=1 and flush=0: all entries, out_* and occupancy are unchanged; out_ready is ignored.
REQ-024 Simultaneous input and output transfer in a full single-entry stage replaces the entry in the same edge with no bubble.
REQ-025 out_valid=1 with out_ready=0 keeps out_ir/out_pc stable until transfer or flush.
REQ-026 bubble_cnt increments by 1 on each edge where out_valid=0; it saturates at 16'hFFFF and does not wrap; hold does not stop it; flush does not clear it.

Reset
REQ-027 While rst=0 (asynchronously): out_valid=0, out_ir=NOP_INSN, out_pc=0, bubble_cnt=0, all skid state empty, in_ready=0.
REQ-028 In the first cycle after rst deasserts, in_ready=1 unless flush or hold is asserted.
REQ-029 Reset asserted mid-transfer discards all entries; no partial entry survives.

Configuration
REQ-030 Macro PIPE_SKID_EN selects the buffering mode.
REQ-031 PIPE_SKID_EN undefined: single entry; in_ready = (!out_valid || out_ready) && !hold && !flush, combinational.
REQ-032 PIPE_SKID_EN defined: two entries (main plus skid); in_ready is a register equal to "skid empty", further gated by !hold and !flush.
REQ-033 PIPE_SKID_EN defined: an entry accepted while main is full and not transferring goes to skid; skid moves to main on the next output transfer.
REQ-034 PIPE_SKID_EN defined: full throughput of one entry per cycle when out_ready=1 continuously; occupancy never exceeds 2.

Verification
REQ-035 Reset release, then in_valid=1 with in_ir=0x00A00093 and in_pc=0x100, out_ready=1 -> next cycle out_valid=1, out_ir=0x00A00093, out_pc=0x100.
REQ-036 Stream of 8 entries, pc 0x0..0x1C, out_ready=1 -> 8 consecutive outputs in order with no bubble.
REQ-037 out_valid=1 (pc=0x40), hold=1 for 3 cycles, in_valid=1 -> in_ready=0 for those cycles and out_pc stays 0x40; resumes after hold=0.
REQ-038 Stage full, flush=1 together with in_valid=1 (pc=0x80) -> next cycle out_valid=0, out_ir=0x00000013, out_pc=0; pc 0x80 never appears.
REQ-039 PIPE_SKID_EN defined, out_ready=0 for 2 cycles during a stream -> occupancy reaches 2, in_ready=0 registered, no entry lost when out_ready returns to 1.
REQ-040 Idle for 70000 cycles after reset -> bubble_cnt=16'hFFFF and holds; rst=0 -> bubble_cnt=0 immediately.
